// File: rtl/ureg_pkg.sv
// Shared definitions for the ureg universal register: MODE codes and widths.
// MODE 3'b111 decodes as DEC only when UREG_DEC_EN is defined.
package ureg_pkg;

  localparam int UREG_MODE_W = 3;

  localparam logic [UREG_MODE_W-1:0] UREG_HOLD = 3'b000;
  localparam logic [UREG_MODE_W-1:0] UREG_LOAD = 3'b001;
  localparam logic [UREG_MODE_W-1:0] UREG_SHL  = 3'b010;
  localparam logic [UREG_MODE_W-1:0] UREG_SHR  = 3'b011;
  localparam logic [UREG_MODE_W-1:0] UREG_ROL  = 3'b100;
  localparam logic [UREG_MODE_W-1:0] UREG_ROR  = 3'b101;
  localparam logic [UREG_MODE_W-1:0] UREG_INC  = 3'b110;
  localparam logic [UREG_MODE_W-1:0] UREG_DEC  = 3'b111;

endpackage

// File: rtl/ureg_next.sv
// Combinational next-state logic for ureg_universal: next Q and next carry/shift-out.
// Optional macro UREG_DEC_EN turns MODE 3'b111 into a decrement with borrow.
module ureg_next
  import ureg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]       q,
  input  logic [WIDTH-1:0]       d,
  input  logic [UREG_MODE_W-1:0] mode,
  input  logic                   sin_l,
  input  logic                   sin_r,
  output logic [WIDTH-1:0]       q_next,
  output logic                   co_next
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Mode decode: every mode drives both outputs; carry is zero unless the mode produces one
  always_comb begin
    q_next  = q;
    co_next = 1'b0;
    case (mode)
      UREG_HOLD: begin
        q_next  = q;
        co_next = 1'b0;
      end
      UREG_LOAD: begin
        q_next  = d;
        co_next = 1'b0;
      end
      UREG_SHL: begin
        q_next  = {q[WIDTH-2:0], sin_r};
        co_next = q[WIDTH-1];
      end
      UREG_SHR: begin
        q_next  = {sin_l, q[WIDTH-1:1]};
        co_next = q[0];
      end
      UREG_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        co_next = q[WIDTH-1];
      end
      UREG_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        co_next = q[0];
      end
      UREG_INC: begin
        q_next  = q + ONE;
        co_next = &q;
      end
      UREG_DEC: begin
`ifdef UREG_DEC_EN
        // Borrow out is set only when wrapping from zero to all-ones
        q_next  = q - ONE;
        co_next = ~|q;
`else
        q_next  = q;
        co_next = 1'b0;
`endif
      end
      default: begin
        q_next  = q;
        co_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ureg_universal.sv
// WIDTH-bit universal register (load/shift/rotate/count) with registered carry and zero flag.
// Optional macro UREG_DEC_EN enables MODE 3'b111 as decrement.
module ureg_universal
  import ureg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                   clock,
  input  logic                   RST,
  input  logic                   ST,
  input  logic [UREG_MODE_W-1:0] MODE,
  input  logic [WIDTH-1:0]       D,
  input  logic                   SIN_R,
  input  logic                   SIN_L,
  output logic [WIDTH-1:0]       Q,
  output logic                   CO,
  output logic                   ZERO
);

  logic [WIDTH-1:0] q_r;
  logic             co_r;
  logic [WIDTH-1:0] q_next_s;
  logic             co_next_s;

  ureg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q       (q_r),
    .d       (D),
    .mode    (MODE),
    .sin_l   (SIN_L),
    .sin_r   (SIN_R),
    .q_next  (q_next_s),
    .co_next (co_next_s)
  );

  // State register: async reset, updates only on enabled edges
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      q_r  <= RESET_VAL;
      co_r <= 1'b0;
    end else if (ST) begin
      q_r  <= q_next_s;
      co_r <= co_next_s;
    end else begin
      q_r  <= q_r;
      co_r <= co_r;
    end
  end

  assign Q    = q_r;
  assign CO   = co_r;
  assign ZERO = ~|q_r;

endmodule

// File: tb/tb_ureg_universal.sv
// Self-checking bench for ureg_universal (WIDTH=4, RESET_VAL=0): vector table, reset sequence, random model run.
module tb_ureg_universal;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         RST;
  logic         ST;
  logic [2:0]   MODE;
  logic [W-1:0] D;
  logic         SIN_R;
  logic         SIN_L;
  logic [W-1:0] Q;
  logic         CO;
  logic         ZERO;

  always #5 clock = ~clock;

  ureg_universal #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clock (clock),
    .RST   (RST),
    .ST    (ST),
    .MODE  (MODE),
    .D     (D),
    .SIN_R (SIN_R),
    .SIN_L (SIN_L),
    .Q     (Q),
    .CO    (CO),
    .ZERO  (ZERO)
  );

  typedef struct {
    logic         st;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] q;
    logic         co;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] q;
    logic         co;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[23];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [W-1:0] q_m;
  logic         co_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic step(input string name, input logic st, input logic [2:0] mode, input logic [W-1:0] d,
                      input logic sin_r, input logic sin_l, input logic [W-1:0] eq, input logic eco);
    exp_t e;
    ST = st; MODE = mode; D = d; SIN_R = sin_r; SIN_L = sin_l;
    sbq.push_back('{q: eq, co: eco});
    @(posedge clock);
    #1;
    if (sbq.size() == 0) begin
      check({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({name, "_q"}, {28'd0, Q}, {28'd0, e.q});
      check({name, "_co"}, {31'd0, CO}, {31'd0, e.co});
      check({name, "_zero"}, {31'd0, ZERO}, {31'd0, (e.q == 4'b0000)});
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] q, input logic [2:0] mode, input logic [W-1:0] d,
                                 input logic sin_r, input logic sin_l);
    exp_t r;
    r.q  = q;
    r.co = 1'b0;
    case (mode)
      3'd1: r.q = d;
      3'd2: begin r.q = (q << 1) | {3'b000, sin_r}; r.co = q[3]; end
      3'd3: begin r.q = (q >> 1) | {sin_l, 3'b000}; r.co = q[0]; end
      3'd4: begin r.q = (q << 1) | (q >> 3); r.co = q[3]; end
      3'd5: begin r.q = (q >> 1) | (q << 3); r.co = q[0]; end
      3'd6: begin r.q = 4'((int'(q) + 1) % 16); r.co = (q == 4'b1111); end
`ifdef UREG_DEC_EN
      3'd7: begin r.q = 4'((int'(q) + 15) % 16); r.co = (q == 4'b0000); end
`endif
      default: r.q = q;
    endcase
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //         st    mode    d        sin_r sin_l  q        co
    vecs[0]  = '{1'b1, 3'b001, 4'b1100, 1'b0, 1'b0, 4'b1100, 1'b0};
    vecs[1]  = '{1'b0, 3'b001, 4'b0110, 1'b0, 1'b0, 4'b1100, 1'b0};
    vecs[2]  = '{1'b0, 3'b001, 4'b0110, 1'b0, 1'b0, 4'b1100, 1'b0};
    vecs[3]  = '{1'b0, 3'b001, 4'b0110, 1'b0, 1'b0, 4'b1100, 1'b0};
    vecs[4]  = '{1'b1, 3'b010, 4'b0000, 1'b1, 1'b0, 4'b1001, 1'b1};
    vecs[5]  = '{1'b1, 3'b011, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1};
    vecs[6]  = '{1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1};
    vecs[7]  = '{1'b1, 3'b000, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0};
    vecs[8]  = '{1'b1, 3'b001, 4'b1101, 1'b0, 1'b0, 4'b1101, 1'b0};
    vecs[9]  = '{1'b1, 3'b100, 4'b0000, 1'b0, 1'b0, 4'b1011, 1'b1};
    vecs[10] = '{1'b1, 3'b101, 4'b0000, 1'b0, 1'b0, 4'b1101, 1'b1};
    vecs[11] = '{1'b1, 3'b001, 4'b1110, 1'b0, 1'b0, 4'b1110, 1'b0};
    vecs[12] = '{1'b1, 3'b110, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0};
    vecs[13] = '{1'b1, 3'b110, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[14] = '{1'b1, 3'b110, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[15] = '{1'b1, 3'b001, 4'b0011, 1'b0, 1'b0, 4'b0011, 1'b0};
    vecs[16] = '{1'b1, 3'b101, 4'b0000, 1'b0, 1'b0, 4'b1001, 1'b1};
`ifdef UREG_DEC_EN
    vecs[17] = '{1'b1, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0};
    vecs[18] = '{1'b1, 3'b001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[19] = '{1'b1, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1};
`else
    vecs[17] = '{1'b1, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[18] = '{1'b1, 3'b001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[19] = '{1'b1, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
`endif
    vecs[20] = '{1'b1, 3'b001, 4'b0110, 1'b0, 1'b0, 4'b0110, 1'b0};
    vecs[21] = '{1'b1, 3'b011, 4'b0000, 1'b0, 1'b1, 4'b1011, 1'b0};
    vecs[22] = '{1'b1, 3'b010, 4'b0000, 1'b0, 1'b0, 4'b0110, 1'b1};

    RST = 1'b1; ST = 1'b0; MODE = 3'b000; D = 4'b0000; SIN_R = 1'b0; SIN_L = 1'b0;
    #1;
    check("reset_q", {28'd0, Q}, 32'd0);
    check("reset_co", {31'd0, CO}, 32'd0);
    check("reset_zero", {31'd0, ZERO}, 32'd1);
    ST = 1'b1; MODE = 3'b001; D = 4'b1111;
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold_q", {28'd0, Q}, 32'd0);
    @(negedge clock);
    RST = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step($sformatf("vec%0d", i), vecs[i].st, vecs[i].mode, vecs[i].d, vecs[i].sin_r, vecs[i].sin_l,
           vecs[i].q, vecs[i].co);
    end

    // Reset asserted mid-cycle with CO set must clear before the next edge
    step("pre_rst_load", 1'b1, 3'b001, 4'b1100, 1'b0, 1'b0, 4'b1100, 1'b0);
    step("pre_rst_rol", 1'b1, 3'b100, 4'b0000, 1'b0, 1'b0, 4'b1001, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_q", {28'd0, Q}, 32'd0);
    check("async_rst_co", {31'd0, CO}, 32'd0);
    check("async_rst_zero", {31'd0, ZERO}, 32'd1);
    ST = 1'b1; MODE = 3'b001; D = 4'b1010;
    @(posedge clock);
    #1;
    check("rst_override_q", {28'd0, Q}, 32'd0);
    @(negedge clock);
    RST = 1'b0;
    step("post_rst_load", 1'b1, 3'b001, 4'b1010, 1'b0, 1'b0, 4'b1010, 1'b0);

    q_m  = 4'b1010;
    co_m = 1'b0;
    for (int k = 0; k < 60; k++) begin
      logic         st_v;
      logic [2:0]   mode_v;
      logic [W-1:0] d_v;
      logic         sr_v;
      logic         sl_v;
      exp_t         nx;
      st_v   = ($urandom_range(0, 3) != 0);
      mode_v = 3'($urandom_range(0, 7));
      d_v    = 4'($urandom_range(0, 15));
      sr_v   = 1'($urandom_range(0, 1));
      sl_v   = 1'($urandom_range(0, 1));
      nx = model(q_m, mode_v, d_v, sr_v, sl_v);
      if (st_v) begin
        q_m  = nx.q;
        co_m = nx.co;
      end
      step($sformatf("rnd%0d", k), st_v, mode_v, d_v, sr_v, sl_v, q_m, co_m);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
